// File: rtl/boid_frame_sequencer_pkg.sv
// Shared constants and FSM encoding for the boid display-update path.
// Package name is boid_pkg so the cursor overlay can import it without the sequencer.
package boid_pkg;

  localparam int DEFAULT_VIDEO_WIDTH  = 640;
  localparam int DEFAULT_VIDEO_HEIGHT = 480;
  localparam int DEFAULT_PIXEL_COUNT  = DEFAULT_VIDEO_WIDTH * DEFAULT_VIDEO_HEIGHT;
  localparam int DEFAULT_ADDR_WIDTH   = 19;
  localparam int DEFAULT_X_WIDTH      = 10;
  localparam int DEFAULT_Y_WIDTH      = 9;
  localparam int DEFAULT_STAT_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWAP  = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  // Index width for n channels; a single channel still needs a 1-bit index.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/boid_frame_sequencer_if.sv
// Display-RAM write bus: bank swap strobe plus one pixel write per cycle.
interface boid_frame_sequencer_if
  import boid_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic                  bank_swap;
  logic                  pix_we;
  logic [ADDR_WIDTH-1:0] pix_addr;

  modport master (output bank_swap, output pix_we, output pix_addr);
  modport slave  (input  bank_swap, input  pix_we, input  pix_addr);

endinterface

// File: rtl/boid_pixel_addr.sv
// Registered coordinate-to-address stage with on-screen test; shared with the cursor overlay.
// pix address is only updated on an actual write so it holds between writes.
module boid_pixel_addr
  import boid_pkg::*;
#(
  parameter int VIDEO_WIDTH  = DEFAULT_VIDEO_WIDTH,
  parameter int VIDEO_HEIGHT = DEFAULT_VIDEO_HEIGHT,
  parameter int X_WIDTH      = DEFAULT_X_WIDTH,
  parameter int Y_WIDTH      = DEFAULT_Y_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vld_p0,
  input  logic [X_WIDTH-1:0]    x_p0,
  input  logic [Y_WIDTH-1:0]    y_p0,
  input  logic                  valid_p0,
  output logic [ADDR_WIDTH-1:0] addr_p1,
  output logic                  in_bounds_p1,
  output logic                  we_p1,
  output logic                  vld_p1,
  output logic                  valid_p1
);

  logic [ADDR_WIDTH-1:0] addr_p0;
  logic                  in_bounds_p0;
  logic                  we_p0;

  assign in_bounds_p0 = (int'(x_p0) < VIDEO_WIDTH) && (int'(y_p0) < VIDEO_HEIGHT);
  assign we_p0        = vld_p0 && valid_p0 && in_bounds_p0;

  // 640 = 512 + 128, so the standard mode needs only two shifts and adds.
  generate
    if (VIDEO_WIDTH == 640) begin : g_shift
      assign addr_p0 = (ADDR_WIDTH'(y_p0) << 9) + (ADDR_WIDTH'(y_p0) << 7) + ADDR_WIDTH'(x_p0);
    end else begin : g_mul
      assign addr_p0 = ADDR_WIDTH'(y_p0) * ADDR_WIDTH'(VIDEO_WIDTH) + ADDR_WIDTH'(x_p0);
    end
  endgenerate

  // ---- stage p0 -> p1 ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      we_p1   <= 1'b0;
      addr_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      we_p1  <= we_p0;
      if (we_p0) begin
        addr_p1 <= addr_p0;
      end
    end
  end

  always_ff @(posedge clock) begin
    in_bounds_p1 <= in_bounds_p0;
    valid_p1     <= valid_p0;
  end

endmodule

// File: rtl/boid_frame_sequencer.sv
// Per-frame boid plotter: snapshot all boids on screenEnd, swap the display bank,
// then stream one pixel write per valid on-screen boid, with clip/overrun/frame statistics.
module boid_frame_sequencer
  import boid_pkg::*;
#(
  parameter int MAX_BOIDS      = 4,
  parameter int BITS_FOR_BOIDS = index_width(MAX_BOIDS),
  parameter int VIDEO_WIDTH    = DEFAULT_VIDEO_WIDTH,
  parameter int VIDEO_HEIGHT   = DEFAULT_VIDEO_HEIGHT,
  parameter int X_WIDTH        = DEFAULT_X_WIDTH,
  parameter int Y_WIDTH        = DEFAULT_Y_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int STAT_WIDTH     = DEFAULT_STAT_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           screenEnd,
  input  logic [MAX_BOIDS*X_WIDTH-1:0]   boid_x,
  input  logic [MAX_BOIDS*Y_WIDTH-1:0]   boid_y,
  input  logic [MAX_BOIDS-1:0]           boid_valid,
  boid_frame_sequencer_if.master         pix,
  output logic                           busy,
  output logic                           frame_done,
  output logic [BITS_FOR_BOIDS:0]        clipped_count,
  output logic [STAT_WIDTH-1:0]          overrun_count,
  output logic [STAT_WIDTH-1:0]          frame_count
);

  localparam logic [BITS_FOR_BOIDS-1:0] LAST_INDEX = BITS_FOR_BOIDS'(MAX_BOIDS - 1);

  seq_state_t                     state;
  logic [BITS_FOR_BOIDS-1:0]      index;
  logic                           drain_tail;
  logic                           swap_pulse;
  logic [BITS_FOR_BOIDS:0]        clip_acc;
  logic [BITS_FOR_BOIDS:0]        clip_next;
  logic                           clip_hit;

  logic [MAX_BOIDS*X_WIDTH-1:0]   snap_x;
  logic [MAX_BOIDS*Y_WIDTH-1:0]   snap_y;
  logic [MAX_BOIDS-1:0]           snap_valid;

  logic                           vld_p0;
  logic [X_WIDTH-1:0]             x_p0;
  logic [Y_WIDTH-1:0]             y_p0;
  logic                           valid_p0;

  logic [ADDR_WIDTH-1:0]          addr_p1;
  logic                           in_bounds_p1;
  logic                           we_p1;
  logic                           vld_p1;
  logic                           valid_p1;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---- stage p0: select the snapshot entry for the current scan index ----
  assign vld_p0   = (state == SCAN);
  assign x_p0     = snap_x[int'(index)*X_WIDTH +: X_WIDTH];
  assign y_p0     = snap_y[int'(index)*Y_WIDTH +: Y_WIDTH];
  assign valid_p0 = snap_valid[index];

  boid_pixel_addr #(
    .VIDEO_WIDTH  (VIDEO_WIDTH),
    .VIDEO_HEIGHT (VIDEO_HEIGHT),
    .X_WIDTH      (X_WIDTH),
    .Y_WIDTH      (Y_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_pixel_addr (
    .clock        (clock),
    .reset        (reset),
    .vld_p0       (vld_p0),
    .x_p0         (x_p0),
    .y_p0         (y_p0),
    .valid_p0     (valid_p0),
    .addr_p1      (addr_p1),
    .in_bounds_p1 (in_bounds_p1),
    .we_p1        (we_p1),
    .vld_p1       (vld_p1),
    .valid_p1     (valid_p1)
  );

  // ---- stage p1: retire writes and tally clipped boids ----
  assign clip_hit  = vld_p1 && valid_p1 && !in_bounds_p1;
  assign clip_next = clip_acc + (BITS_FOR_BOIDS+1)'(clip_hit);

  assign pix.bank_swap = swap_pulse;
  assign pix.pix_we    = we_p1;
  assign pix.pix_addr  = addr_p1;

  // DRAIN spans two cycles: the last write retires, then frame_done is presented
  // while still busy so a screenEnd in that cycle counts as an overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      index         <= '0;
      drain_tail    <= 1'b0;
      swap_pulse    <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      clip_acc      <= '0;
      clipped_count <= '0;
      overrun_count <= '0;
      frame_count   <= '0;
      snap_x        <= '0;
      snap_y        <= '0;
      snap_valid    <= '0;
    end else begin
      swap_pulse <= 1'b0;
      frame_done <= 1'b0;
      if (screenEnd && (state != IDLE)) begin
        overrun_count <= sat_inc(overrun_count);
      end
      if (clip_hit) begin
        clip_acc <= clip_next;
      end
      case (state)
        IDLE: begin
          if (screenEnd) begin
            snap_x     <= boid_x;
            snap_y     <= boid_y;
            snap_valid <= boid_valid;
            swap_pulse <= 1'b1;
            busy       <= 1'b1;
            state      <= SWAP;
          end
        end
        SWAP: begin
          index    <= '0;
          clip_acc <= '0;
          state    <= SCAN;
        end
        SCAN: begin
          if (index == LAST_INDEX) begin
            state <= DRAIN;
          end else begin
            index <= index + 1'b1;
          end
        end
        DRAIN: begin
          if (!drain_tail) begin
            drain_tail    <= 1'b1;
            frame_done    <= 1'b1;
            clipped_count <= clip_next;
            frame_count   <= frame_count + 1'b1;
          end else begin
            drain_tail <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boid_frame_sequencer.sv
// Bench for boid_frame_sequencer: a 4-boid and a 32-boid instance checked every cycle
// against a frame-schedule model, plus hand-computed expectations per scenario.
module tb_boid_frame_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---- DUT 0: 4 boids ----
  logic        se0 = 1'b0;
  logic [39:0] bx0 = '0;
  logic [35:0] by0 = '0;
  logic [3:0]  bv0 = '0;
  logic        busy0, done0;
  logic [2:0]  clip0;
  logic [15:0] ovr0, fc0;
  boid_frame_sequencer_if #(.ADDR_WIDTH(19)) pix0();

  boid_frame_sequencer #(.MAX_BOIDS(4)) dut0 (
    .clock(clk), .reset(rst), .screenEnd(se0),
    .boid_x(bx0), .boid_y(by0), .boid_valid(bv0),
    .pix(pix0), .busy(busy0), .frame_done(done0),
    .clipped_count(clip0), .overrun_count(ovr0), .frame_count(fc0)
  );

  // ---- DUT 1: 32 boids ----
  logic         se1 = 1'b0;
  logic [319:0] bx1 = '0;
  logic [287:0] by1 = '0;
  logic [31:0]  bv1 = '0;
  logic         busy1, done1;
  logic [5:0]   clip1;
  logic [15:0]  ovr1, fc1;
  boid_frame_sequencer_if #(.ADDR_WIDTH(19)) pix1();

  boid_frame_sequencer #(.MAX_BOIDS(32)) dut1 (
    .clock(clk), .reset(rst), .screenEnd(se1),
    .boid_x(bx1), .boid_y(by1), .boid_valid(bv1),
    .pix(pix1), .busy(busy1), .frame_done(done1),
    .clipped_count(clip1), .overrun_count(ovr1), .frame_count(fc1)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---- frame-schedule model: a frame started at cycle T owns cycles T+1..T+N+3 ----
  int m_active[2];
  int m_T[2];
  int m_ovr[2];
  int m_fcnt[2];
  int m_clip[2];
  int m_x[2][32];
  int m_y[2][32];
  int m_v[2][32];

  function automatic bit on_screen(input int x, input int y);
    return (x < 640) && (y < 480);
  endfunction

  // Observed activity logs used by the scenario checks.
  int wr_cyc0[$];
  int wr_addr0[$];
  int swap_cyc0[$];
  int done_cyc0[$];
  int wr_cyc1[$];
  int wr_addr1[$];
  int swap_cyc1[$];
  int done_cyc1[$];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 0; m_T[d] = 0; m_ovr[d] = 0; m_fcnt[d] = 0; m_clip[d] = 0;
    end
  end

  always @(negedge clk) begin
    if (pix0.pix_we)    begin wr_cyc0.push_back(cyc); wr_addr0.push_back(int'(pix0.pix_addr)); end
    if (pix0.bank_swap) swap_cyc0.push_back(cyc);
    if (done0)          done_cyc0.push_back(cyc);
    if (pix1.pix_we)    begin wr_cyc1.push_back(cyc); wr_addr1.push_back(int'(pix1.pix_addr)); end
    if (pix1.bank_swap) swap_cyc1.push_back(cyc);
    if (done1)          done_cyc1.push_back(cyc);

    for (int d = 0; d < 2; d++) begin
      int n, k, e_addr, cnt;
      bit e_busy, e_swap, e_done, e_we, se;
      longint a_busy, a_swap, a_done, a_we, a_addr, a_clip, a_ovr, a_fc;
      n = (d == 0) ? 4 : 32;
      if (d == 0) begin
        a_busy = busy0; a_swap = pix0.bank_swap; a_done = done0; a_we = pix0.pix_we;
        a_addr = pix0.pix_addr; a_clip = clip0; a_ovr = ovr0; a_fc = fc0; se = se0;
      end else begin
        a_busy = busy1; a_swap = pix1.bank_swap; a_done = done1; a_we = pix1.pix_we;
        a_addr = pix1.pix_addr; a_clip = clip1; a_ovr = ovr1; a_fc = fc1; se = se1;
      end

      if (chk_en) begin
        k      = cyc - m_T[d] - 3;
        e_busy = (m_active[d] != 0) && (cyc >= m_T[d] + 1);
        e_swap = (m_active[d] != 0) && (cyc == m_T[d] + 1);
        e_done = (m_active[d] != 0) && (cyc == m_T[d] + n + 3);
        e_we   = 1'b0;
        e_addr = 0;
        if ((m_active[d] != 0) && (k >= 0) && (k < n)) begin
          e_we   = (m_v[d][k] != 0) && on_screen(m_x[d][k], m_y[d][k]);
          e_addr = m_y[d][k] * 640 + m_x[d][k];
        end
        chk((d == 0) ? "busy0" : "busy1", a_busy, longint'(e_busy));
        chk((d == 0) ? "bank_swap0" : "bank_swap1", a_swap, longint'(e_swap));
        chk((d == 0) ? "frame_done0" : "frame_done1", a_done, longint'(e_done));
        chk((d == 0) ? "pix_we0" : "pix_we1", a_we, longint'(e_we));
        if (e_we) chk((d == 0) ? "pix_addr0" : "pix_addr1", a_addr, longint'(e_addr));
        chk((d == 0) ? "clipped0" : "clipped1", a_clip, longint'(m_clip[d]));
        chk((d == 0) ? "overrun0" : "overrun1", a_ovr, longint'(m_ovr[d]));
        chk((d == 0) ? "frames0" : "frames1", a_fc, longint'(m_fcnt[d]));
      end

      // advance the model with this cycle's inputs
      if (rst) begin
        m_active[d] = 0; m_ovr[d] = 0; m_fcnt[d] = 0; m_clip[d] = 0;
      end else if (m_active[d] != 0) begin
        if (se && m_ovr[d] < 65535) m_ovr[d]++;
        if (cyc == m_T[d] + n + 2) begin
          m_fcnt[d] = (m_fcnt[d] + 1) & 16'hFFFF;
          cnt = 0;
          for (int j = 0; j < n; j++)
            if ((m_v[d][j] != 0) && !on_screen(m_x[d][j], m_y[d][j])) cnt++;
          m_clip[d] = cnt;
        end
        if (cyc == m_T[d] + n + 3) m_active[d] = 0;
      end else if (se) begin
        m_active[d] = 1;
        m_T[d] = cyc;
        for (int j = 0; j < n; j++) begin
          if (d == 0) begin
            m_x[d][j] = int'(bx0[j*10 +: 10]); m_y[d][j] = int'(by0[j*9 +: 9]); m_v[d][j] = int'(bv0[j]);
          end else begin
            m_x[d][j] = int'(bx1[j*10 +: 10]); m_y[d][j] = int'(by1[j*9 +: 9]); m_v[d][j] = int'(bv1[j]);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set0(input int k, input int x, input int y);
    bx0[k*10 +: 10] = 10'(x);
    by0[k*9 +: 9]   = 9'(y);
  endtask

  task automatic clear_logs0();
    wr_cyc0.delete(); wr_addr0.delete(); swap_cyc0.delete(); done_cyc0.delete();
  endtask

  int T;
  int exp_addr[4];

  initial begin
    // ---- reset ----
    steps(2);
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", busy0, 0);
    chk("rst_we", pix0.pix_we, 0);
    chk("rst_addr", pix0.pix_addr, 0);
    chk("rst_swap", pix0.bank_swap, 0);
    chk("rst_frames", fc0, 0);
    chk("rst_overrun", ovr0, 0);
    step();

    // ---- four in-bounds boids ----
    clear_logs0();
    set0(0, 0, 0); set0(1, 639, 479); set0(2, 10, 10); set0(3, 320, 240);
    bv0 = 4'b1111;
    se0 = 1'b1; T = cyc; step(); se0 = 1'b0;
    steps(9);
    exp_addr = '{0, 307199, 6410, 153920};
    chk("t1_swap_n", swap_cyc0.size(), 1);
    if (swap_cyc0.size() > 0) chk("t1_swap_cyc", swap_cyc0[0] - T, 1);
    chk("t1_writes", wr_addr0.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr0.size(); i++) begin
      chk("t1_addr", wr_addr0[i], exp_addr[i]);
      chk("t1_wcyc", wr_cyc0[i] - T, 3 + i);
    end
    chk("t1_done_n", done_cyc0.size(), 1);
    if (done_cyc0.size() > 0) chk("t1_done_cyc", done_cyc0[0] - T, 7);
    chk("t1_clip", clip0, 0);
    chk("t1_frames", fc0, 1);

    // ---- valid mask and clipping ----
    clear_logs0();
    set0(0, 1, 1); set0(1, 5, 5); set0(2, 2, 2); set0(3, 640, 5);
    bv0 = 4'b1010;
    se0 = 1'b1; step(); se0 = 1'b0;
    steps(9);
    chk("t2_writes", wr_addr0.size(), 1);
    if (wr_addr0.size() > 0) chk("t2_addr", wr_addr0[0], 3205);
    chk("t2_clip", clip0, 1);

    // ---- inputs changing after the snapshot ----
    clear_logs0();
    set0(0, 1, 2); set0(1, 3, 4); set0(2, 100, 0); set0(3, 0, 479);
    bv0 = 4'b1111;
    se0 = 1'b1; step(); se0 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bx0 = {10'(7 * i + 3), 10'(11 * i + 1), 10'(13 * i + 5), 10'(17 * i + 2)};
      step();
    end
    exp_addr = '{1281, 2563, 100, 306560};
    chk("t3_writes", wr_addr0.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr0.size(); i++) chk("t3_addr", wr_addr0[i], exp_addr[i]);
    chk("t3_clip", clip0, 0);

    // ---- overruns at T+2 and T+7 ----
    clear_logs0();
    T = cyc;
    for (int i = 0; i < 12; i++) begin
      se0 = (i == 0 || i == 2 || i == 7);
      step();
    end
    se0 = 1'b0;
    chk("t4_overrun", ovr0, 2);
    chk("t4_swap_n", swap_cyc0.size(), 1);
    chk("t4_done_n", done_cyc0.size(), 1);
    chk("t4_frames", fc0, 4);

    // ---- reset mid-scan ----
    clear_logs0();
    T = cyc;
    se0 = 1'b1; step(); se0 = 1'b0;
    steps(3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_we", pix0.pix_we, 0);
    chk("t5_busy", busy0, 0);
    steps(8);
    chk("t5_done_n", done_cyc0.size(), 0);
    chk("t5_frames", fc0, 0);
    chk("t5_overrun", ovr0, 0);
    chk("t5_clip", clip0, 0);
    clear_logs0();
    se0 = 1'b1; step(); se0 = 1'b0;
    steps(9);
    chk("t5_writes", wr_addr0.size(), 4);
    chk("t5_done_after", done_cyc0.size(), 1);
    chk("t5_frames_after", fc0, 1);

    // ---- 32 boids: saturating overruns, then one clean frame ----
    for (int k = 0; k < 32; k++) begin
      bx1[k*10 +: 10] = 10'(k * 19);
      by1[k*9 +: 9]   = 9'(k * 15);
    end
    bv1 = '1;
    se1 = 1'b1;
    steps(68000);
    se1 = 1'b0;
    steps(40);
    chk("t6_overrun_sat", ovr1, 65535);
    wr_cyc1.delete(); wr_addr1.delete(); done_cyc1.delete(); swap_cyc1.delete();
    T = cyc;
    se1 = 1'b1; step(); se1 = 1'b0;
    steps(40);
    chk("t6_writes", wr_addr1.size(), 32);
    for (int k = 0; k < 32 && k < wr_addr1.size(); k++) begin
      chk("t6_addr", wr_addr1[k], k * 15 * 640 + k * 19);
      chk("t6_wcyc", wr_cyc1[k] - T, 3 + k);
    end
    chk("t6_done_n", done_cyc1.size(), 1);
    if (done_cyc1.size() > 0) chk("t6_done_cyc", done_cyc1[0] - T, 35);
    chk("t6_overrun_hold", ovr1, 65535);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
